// File: rtl/lemon_rf_pkg.sv
// Shared types and widths for the integer register file write-back path.
package lemon_rf_pkg;

    localparam int RF_ADDR_WIDTH = 5;
    localparam int RF_DATA_WIDTH = 64;

    typedef enum logic {
        WB_EX = 1'b0,
        WB_LS = 1'b1
    } wb_src_e;

    typedef struct packed {
        logic                     valid;
        logic [RF_ADDR_WIDTH-1:0] rd;
        logic [RF_DATA_WIDTH-1:0] data;
    } wb_req_t;

endpackage

// File: rtl/rf_wb_sched_rr_arb2.sv
// Two-requester round-robin arbiter; the pointer names the side preferred on a tie.
module rr_arb2
    import lemon_rf_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    output logic [1:0] gnt
);

    wb_src_e ptr;

    // NOTE: every output of a combinational block gets a default first so no latch is inferred.
    always_comb begin
        gnt = 2'b00;
        if (req[WB_EX] && (!req[WB_LS] || ptr == WB_EX))
            gnt[WB_EX] = 1'b1;
        else if (req[WB_LS])
            gnt[WB_LS] = 1'b1;
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            ptr <= WB_EX;
        else if (gnt[WB_EX])
            ptr <= WB_LS;
        else if (gnt[WB_LS])
            ptr <= WB_EX;
    end

endmodule

// File: rtl/rf_wb_sched.sv
// Write-back scheduler and RAW/WAW scoreboard in front of the single-write-port register file.
// ADDR_WIDTH/DATA_WIDTH must equal the package widths carried by wb_req_t.
module rf_wb_sched
    import lemon_rf_pkg::*;
#(
    parameter int ADDR_WIDTH = RF_ADDR_WIDTH,
    parameter int DATA_WIDTH = RF_DATA_WIDTH
) (
    input  logic                         clk,
    input  logic                         rst,

    input  logic                         issue_valid,
    input  logic                         issue_wr,
    input  logic [ADDR_WIDTH-1:0]        issue_rd,
    input  logic [ADDR_WIDTH-1:0]        issue_rs1,
    input  logic [ADDR_WIDTH-1:0]        issue_rs2,
    output logic                         issue_ready,

    input  logic                         ex_valid,
    input  logic [ADDR_WIDTH-1:0]        ex_rd,
    input  logic [DATA_WIDTH-1:0]        ex_data,
    output logic                         ex_ready,

    input  logic                         ls_valid,
    input  logic [ADDR_WIDTH-1:0]        ls_rd,
    input  logic [DATA_WIDTH-1:0]        ls_data,
    output logic                         ls_ready,

    output logic                         rf_wen,
    output logic [ADDR_WIDTH-1:0]        rf_rd,
    output logic [DATA_WIDTH-1:0]        rf_dataD,
    output logic [(1<<ADDR_WIDTH)-1:0]   busy_vec
);

    localparam int NREG = 1 << ADDR_WIDTH;

    wb_req_t          ex_req, ls_req, win_req;
    logic [1:0]       gnt;
    logic             grant;
    logic             issue_fire;
    logic [NREG-1:0]  busy_eff;
    logic [NREG-1:0]  set_mask, clr_mask;

    assign ex_req = '{valid: ex_valid, rd: ex_rd, data: ex_data};
    assign ls_req = '{valid: ls_valid, rd: ls_rd, data: ls_data};

    rr_arb2 u_arb (
        .clk (clk),
        .rst (rst),
        .req ({ls_req.valid, ex_req.valid}),
        .gnt (gnt)
    );

    assign ex_ready = gnt[WB_EX];
    assign ls_ready = gnt[WB_LS];
    assign grant    = |gnt;
    assign win_req  = gnt[WB_LS] ? ls_req : ex_req;

    // x0 is hardwired, so it never blocks issue.
    assign busy_eff    = {busy_vec[NREG-1:1], 1'b0};
    assign issue_ready = !busy_eff[issue_rs1] && !busy_eff[issue_rs2] &&
                         !(issue_wr && busy_eff[issue_rd]);
    assign issue_fire  = issue_valid && issue_ready;

    always_comb begin
        set_mask = '0;
        clr_mask = '0;
        if (issue_fire && issue_wr && issue_rd != '0)
            set_mask[issue_rd] = 1'b1;
        if (rf_wen)
            clr_mask[rf_rd] = 1'b1;
    end

    // Applying the set after the clear lets a new writer win over a retiring one on the same index.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            busy_vec <= '0;
        else
            busy_vec <= (busy_vec & ~clr_mask) | set_mask;
    end

    // NOTE: only control/state flops are reset; rf_rd/rf_dataD are reset too because their
    // reset value is visible on the port.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rf_wen   <= 1'b0;
            rf_rd    <= '0;
            rf_dataD <= '0;
        end else begin
            rf_wen <= grant && win_req.rd != '0;
            if (grant && win_req.rd != '0) begin
                rf_rd    <= win_req.rd;
                rf_dataD <= win_req.data;
            end
        end
    end

endmodule

// File: tb/tb_rf_wb_sched.sv
// Directed self-checking bench for rf_wb_sched.
module tb_rf_wb_sched;

    localparam int AW = 5;
    localparam int DW = 64;

    logic          clk = 1'b0;
    logic          rst;
    logic          issue_valid, issue_wr;
    logic [AW-1:0] issue_rd, issue_rs1, issue_rs2;
    logic          issue_ready;
    logic          ex_valid, ls_valid;
    logic [AW-1:0] ex_rd, ls_rd;
    logic [DW-1:0] ex_data, ls_data;
    logic          ex_ready, ls_ready;
    logic          rf_wen;
    logic [AW-1:0] rf_rd;
    logic [DW-1:0] rf_dataD;
    logic [31:0]   busy_vec;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    rf_wb_sched #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .clk         (clk),
        .rst         (rst),
        .issue_valid (issue_valid),
        .issue_wr    (issue_wr),
        .issue_rd    (issue_rd),
        .issue_rs1   (issue_rs1),
        .issue_rs2   (issue_rs2),
        .issue_ready (issue_ready),
        .ex_valid    (ex_valid),
        .ex_rd       (ex_rd),
        .ex_data     (ex_data),
        .ex_ready    (ex_ready),
        .ls_valid    (ls_valid),
        .ls_rd       (ls_rd),
        .ls_data     (ls_data),
        .ls_ready    (ls_ready),
        .rf_wen      (rf_wen),
        .rf_rd       (rf_rd),
        .rf_dataD    (rf_dataD),
        .busy_vec    (busy_vec)
    );

    // Advance past the next rising edge; inputs are driven and outputs sampled here.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        issue_valid = 0; issue_wr = 0; issue_rd = 0; issue_rs1 = 0; issue_rs2 = 0;
        ex_valid = 0; ex_rd = 0; ex_data = 0;
        ls_valid = 0; ls_rd = 0; ls_data = 0;
    endtask

    task automatic apply_reset();
        rst = 1;
        tick();
        tick();
        rst = 0;
        #1;
    endtask

    task automatic test_reset();
        n_checks++; if (busy_vec !== 32'h0) begin n_fail++; $display("FAIL reset_busy: got %h exp 0", busy_vec); end
        n_checks++; if (rf_wen !== 1'b0) begin n_fail++; $display("FAIL reset_wen: got %b exp 0", rf_wen); end
        n_checks++; if (rf_rd !== 5'd0) begin n_fail++; $display("FAIL reset_rd: got %0d exp 0", rf_rd); end
        n_checks++; if (rf_dataD !== 64'h0) begin n_fail++; $display("FAIL reset_data: got %h exp 0", rf_dataD); end
        // Build busy[5]=1 and rf_wen=1, then reset mid-cycle.
        issue_valid = 1; issue_wr = 1; issue_rd = 5;
        tick();
        issue_valid = 0; issue_wr = 0; issue_rd = 0;
        ex_valid = 1; ex_rd = 6; ex_data = 64'h1;
        tick();
        ex_valid = 0;
        n_checks++; if (busy_vec !== 32'h20) begin n_fail++; $display("FAIL pre_reset_busy: got %h exp 20", busy_vec); end
        n_checks++; if (rf_wen !== 1'b1) begin n_fail++; $display("FAIL pre_reset_wen: got %b exp 1", rf_wen); end
        #2;
        rst = 1;
        ex_valid = 1; ex_rd = 3; ex_data = 64'h33;
        ls_valid = 1; ls_rd = 4; ls_data = 64'h44;
        #1;
        n_checks++; if (busy_vec !== 32'h0) begin n_fail++; $display("FAIL async_reset_busy: got %h exp 0", busy_vec); end
        n_checks++; if (rf_wen !== 1'b0) begin n_fail++; $display("FAIL async_reset_wen: got %b exp 0", rf_wen); end
        tick();
        rst = 0;
        #1;
        n_checks++; if (ex_ready !== 1'b1 || ls_ready !== 1'b0) begin
            n_fail++; $display("FAIL post_reset_grant: got ex=%b ls=%b exp ex=1 ls=0", ex_ready, ls_ready);
        end
        tick();
        idle_inputs();
        n_checks++; if (rf_wen !== 1'b1 || rf_rd !== 5'd3 || rf_dataD !== 64'h33) begin
            n_fail++; $display("FAIL post_reset_write: got wen=%b rd=%0d data=%h exp 1/3/33", rf_wen, rf_rd, rf_dataD);
        end
        tick();
    endtask

    task automatic test_raw();
        issue_valid = 1; issue_wr = 1; issue_rd = 5;
        #1;
        n_checks++; if (issue_ready !== 1'b1) begin n_fail++; $display("FAIL raw_first_issue: got %b exp 1", issue_ready); end
        tick();
        issue_wr = 0; issue_rd = 0; issue_rs1 = 5;
        #1;
        n_checks++; if (issue_ready !== 1'b0) begin n_fail++; $display("FAIL raw_stall: got %b exp 0", issue_ready); end
        ex_valid = 1; ex_rd = 5; ex_data = 64'h1234;
        #1;
        n_checks++; if (ex_ready !== 1'b1) begin n_fail++; $display("FAIL raw_ex_ready: got %b exp 1", ex_ready); end
        tick();
        ex_valid = 0;
        n_checks++; if (rf_wen !== 1'b1 || rf_rd !== 5'd5 || rf_dataD !== 64'h1234) begin
            n_fail++; $display("FAIL raw_write: got wen=%b rd=%0d data=%h exp 1/5/1234", rf_wen, rf_rd, rf_dataD);
        end
        n_checks++; if (issue_ready !== 1'b0) begin n_fail++; $display("FAIL raw_still_stalled: got %b exp 0", issue_ready); end
        tick();
        n_checks++; if (issue_ready !== 1'b1) begin n_fail++; $display("FAIL raw_release: got %b exp 1", issue_ready); end
        n_checks++; if (busy_vec !== 32'h0) begin n_fail++; $display("FAIL raw_busy_clear: got %h exp 0", busy_vec); end
        tick();
        idle_inputs();
        tick();
    endtask

    task automatic test_back_to_back();
        logic exp_ex;
        apply_reset();
        ex_valid = 1; ex_rd = 3; ex_data = 64'haaaa;
        ls_valid = 1; ls_rd = 4; ls_data = 64'hbbbb;
        for (int i = 0; i < 4; i++) begin
            #1;
            exp_ex = (i % 2 == 0);
            n_checks++; if (ex_ready !== exp_ex || ls_ready !== !exp_ex) begin
                n_fail++; $display("FAIL rr_grant[%0d]: got ex=%b ls=%b exp ex=%b ls=%b", i, ex_ready, ls_ready, exp_ex, !exp_ex);
            end
            if (i > 0) begin
                n_checks++; if (rf_wen !== 1'b1 || rf_rd !== (exp_ex ? 5'd4 : 5'd3)) begin
                    n_fail++; $display("FAIL rr_write[%0d]: got wen=%b rd=%0d exp 1/%0d", i, rf_wen, rf_rd, exp_ex ? 4 : 3);
                end
            end
            tick();
        end
        idle_inputs();
        n_checks++; if (rf_wen !== 1'b1 || rf_rd !== 5'd4 || rf_dataD !== 64'hbbbb) begin
            n_fail++; $display("FAIL rr_last_write: got wen=%b rd=%0d data=%h exp 1/4/bbbb", rf_wen, rf_rd, rf_dataD);
        end
        tick();
        n_checks++; if (rf_wen !== 1'b0 || rf_rd !== 5'd4) begin
            n_fail++; $display("FAIL rr_idle_hold: got wen=%b rd=%0d exp 0/4", rf_wen, rf_rd);
        end
    endtask

    task automatic test_ls_only();
        issue_valid = 1; issue_wr = 1; issue_rd = 7;
        tick();
        idle_inputs();
        ls_valid = 1; ls_rd = 7; ls_data = 64'hdead_beef;
        #1;
        n_checks++; if (ls_ready !== 1'b1 || ex_ready !== 1'b0) begin
            n_fail++; $display("FAIL ls_grant: got ex=%b ls=%b exp ex=0 ls=1", ex_ready, ls_ready);
        end
        n_checks++; if (busy_vec !== 32'h80) begin n_fail++; $display("FAIL ls_busy_set: got %h exp 80", busy_vec); end
        tick();
        ls_valid = 0;
        n_checks++; if (rf_wen !== 1'b1 || rf_rd !== 5'd7 || rf_dataD !== 64'hdead_beef) begin
            n_fail++; $display("FAIL ls_write: got wen=%b rd=%0d data=%h exp 1/7/deadbeef", rf_wen, rf_rd, rf_dataD);
        end
        n_checks++; if (busy_vec[7] !== 1'b1) begin n_fail++; $display("FAIL ls_busy_held: got %b exp 1", busy_vec[7]); end
        tick();
        n_checks++; if (busy_vec !== 32'h0 || rf_wen !== 1'b0) begin
            n_fail++; $display("FAIL ls_busy_clear: got busy=%h wen=%b exp 0/0", busy_vec, rf_wen);
        end
    endtask

    task automatic test_x0();
        issue_valid = 1; issue_wr = 1; issue_rd = 0;
        #1;
        n_checks++; if (issue_ready !== 1'b1) begin n_fail++; $display("FAIL x0_issue_ready: got %b exp 1", issue_ready); end
        tick();
        idle_inputs();
        n_checks++; if (busy_vec !== 32'h0) begin n_fail++; $display("FAIL x0_busy: got %h exp 0", busy_vec); end
        ex_valid = 1; ex_rd = 0; ex_data = 64'hff;
        #1;
        n_checks++; if (ex_ready !== 1'b1) begin n_fail++; $display("FAIL x0_ex_ready: got %b exp 1", ex_ready); end
        tick();
        ex_valid = 0;
        n_checks++; if (rf_wen !== 1'b0 || busy_vec !== 32'h0) begin
            n_fail++; $display("FAIL x0_write: got wen=%b busy=%h exp 0/0", rf_wen, busy_vec);
        end
        tick();
    endtask

    task automatic test_waw();
        issue_valid = 1; issue_wr = 1; issue_rd = 9;
        tick();
        #1;
        n_checks++; if (issue_ready !== 1'b0) begin n_fail++; $display("FAIL waw_stall: got %b exp 0", issue_ready); end
        tick();
        n_checks++; if (issue_ready !== 1'b0) begin n_fail++; $display("FAIL waw_stall_hold: got %b exp 0", issue_ready); end
        ex_valid = 1; ex_rd = 9; ex_data = 64'h99;
        tick();
        ex_valid = 0;
        n_checks++; if (rf_wen !== 1'b1 || rf_rd !== 5'd9 || issue_ready !== 1'b0) begin
            n_fail++; $display("FAIL waw_write: got wen=%b rd=%0d ready=%b exp 1/9/0", rf_wen, rf_rd, issue_ready);
        end
        tick();
        n_checks++; if (issue_ready !== 1'b1) begin n_fail++; $display("FAIL waw_release: got %b exp 1", issue_ready); end
        tick();
        idle_inputs();
        n_checks++; if (busy_vec !== 32'h200) begin n_fail++; $display("FAIL waw_rebusy: got %h exp 200", busy_vec); end
    endtask

    initial begin
        idle_inputs();
        apply_reset();
        test_reset();
        test_raw();
        test_back_to_back();
        test_ls_only();
        test_x0();
        test_waw();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
